univ_shift_reg: RTL and testbench

Parametrised universal shift register, the next generation of the team's fixed 4-bit serial-in/serial-out register. Supports hold, shift-right, shift-left and parallel-load modes, with configurable width. It keeps a shift counter and produces a one-cycle frame-complete pulse after WIDTH shifts. Used as the serialiser/deserialiser primitive in the team's serial datapath blocks.

---
 rtl/univ_shift_reg.sv | 106 ++++++++++
 tb/tb_univ_shift_reg.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift right/left and parallel load, with a
// per-frame shift counter that pulses frame_done after every WIDTH shifts.
module univ_shift_reg #(
  parameter  int               WIDTH     = 4,
  parameter  logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  localparam int               CW        = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             din,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] o,
  output logic             dout,
  output logic [CW-1:0]    cnt,
  output logic             frame_done
);

  if (WIDTH < 2) begin : g_width_check
    $error("univ_shift_reg: WIDTH must be at least 2");
  end

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] o_q, o_d;
  logic             dout_q, dout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             frame_done_q, frame_done_d;
  logic             shift_s;

  // Next-state decode; frame_done defaults low so it can only ever be a pulse.
  always_comb begin
    o_d          = o_q;
    dout_d       = dout_q;
    cnt_d        = cnt_q;
    frame_done_d = 1'b0;
    shift_s      = 1'b0;
    if (en) begin
      case (mode)
        MODE_HOLD: begin
          shift_s = 1'b0;
        end
        MODE_RIGHT: begin
          o_d     = {din, o_q[WIDTH-1:1]};
          dout_d  = o_q[0];
          shift_s = 1'b1;
        end
        MODE_LEFT: begin
          o_d     = {o_q[WIDTH-2:0], din};
          dout_d  = o_q[WIDTH-1];
          shift_s = 1'b1;
        end
        MODE_LOAD: begin
          o_d   = d;
          cnt_d = {CW{1'b0}};
        end
        default: begin
          shift_s = 1'b0;
        end
      endcase
    end else begin
      shift_s = 1'b0;
    end

    // Counter keeps running across direction changes; wrap gives back-to-back frames.
    if (shift_s) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d        = {CW{1'b0}};
        frame_done_d = 1'b1;
      end else begin
        cnt_d        = cnt_q + CNT_ONE;
        frame_done_d = 1'b0;
      end
    end else begin
      frame_done_d = 1'b0;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_q          <= RESET_VAL;
      dout_q       <= 1'b0;
      cnt_q        <= {CW{1'b0}};
      frame_done_q <= 1'b0;
    end else begin
      o_q          <= o_d;
      dout_q       <= dout_d;
      cnt_q        <= cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign o          = o_q;
  assign dout       = dout_q;
  assign cnt        = cnt_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=4): vector table driven
// through a scoreboard queue, plus hand-written reset sequences.
module tb_univ_shift_reg;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic       din;
  logic [3:0] d;
  logic [3:0] o;
  logic       dout;
  logic [1:0] cnt;
  logic       frame_done;

  bit clk_run = 1'b1;
  int checks  = 0;
  int errors  = 0;

  typedef struct {
    logic       en;
    logic [1:0] mode;
    logic       din;
    logic [3:0] d;
    logic [3:0] o;
    logic       dout;
    logic [1:0] cnt;
    logic       fd;
  } vec_t;

  typedef struct {
    logic [3:0] o;
    logic       dout;
    logic [1:0] cnt;
    logic       fd;
    int         idx;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  univ_shift_reg #(.WIDTH(4), .RESET_VAL(4'b0000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .mode       (mode),
    .din        (din),
    .d          (d),
    .o          (o),
    .dout       (dout),
    .cnt        (cnt),
    .frame_done (frame_done)
  );

  // Gateable clock, 10 ns period; stopping it keeps the low phase.
  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %b expected %b", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic e, input logic [1:0] m, input logic di, input logic [3:0] dd,
                     input logic [3:0] eo, input logic edo, input logic [1:0] ec, input logic efd);
    vec_t v;
    v.en = e; v.mode = m; v.din = di; v.d = dd;
    v.o = eo; v.dout = edo; v.cnt = ec; v.fd = efd;
    vecs.push_back(v);
  endtask

  // Drive one operation at the falling edge, queue its expectation, compare after the rising edge.
  task automatic step(input logic e, input logic [1:0] m, input logic di, input logic [3:0] dd,
                      input logic [3:0] eo, input logic edo, input logic [1:0] ec, input logic efd,
                      input int idx);
    exp_t x;
    @(negedge clk);
    en = e; mode = m; din = di; d = dd;
    x.o = eo; x.dout = edo; x.cnt = ec; x.fd = efd; x.idx = idx;
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard[%0d]: got empty queue expected an entry", idx);
    end else begin
      x = sb.pop_front();
      check("o",          x.idx, o,                   x.o);
      check("dout",       x.idx, {3'b000, dout},      {3'b000, x.dout});
      check("cnt",        x.idx, {2'b00, cnt},        {2'b00, x.cnt});
      check("frame_done", x.idx, {3'b000, frame_done}, {3'b000, x.fd});
    end
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; en = 1'b0; mode = 2'b00; din = 1'b0; d = 4'b0000;
    #12;
    rst_n = 1'b1;

    // Async reset with clock stopped: first put non-reset state in the register.
    step(1'b1, 2'b11, 1'b0, 4'b1111, 4'b1111, 1'b0, 2'd0, 1'b0, 900);
    step(1'b1, 2'b01, 1'b1, 4'b0000, 4'b1111, 1'b1, 2'd1, 1'b0, 901);
    @(negedge clk);
    clk_run = 1'b0;
    en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_o",    0, o,                    4'b0000);
    check("rst_dout", 0, {3'b000, dout},       4'b0000);
    check("rst_cnt",  0, {2'b00, cnt},         4'b0000);
    check("rst_fd",   0, {3'b000, frame_done}, 4'b0000);
    #3 rst_n = 1'b1;
    clk_run = 1'b1;

    // Shift right din=1,0,1,1
    add(1'b1, 2'b01, 1'b1, 4'b0000, 4'b1000, 1'b0, 2'd1, 1'b0);
    add(1'b1, 2'b01, 1'b0, 4'b0000, 4'b0100, 1'b0, 2'd2, 1'b0);
    add(1'b1, 2'b01, 1'b1, 4'b0000, 4'b1010, 1'b0, 2'd3, 1'b0);
    add(1'b1, 2'b01, 1'b1, 4'b0000, 4'b1101, 1'b0, 2'd0, 1'b1);
    // Load 1001 then shift left 8 times with din=0
    add(1'b1, 2'b11, 1'b0, 4'b1001, 4'b1001, 1'b0, 2'd0, 1'b0);
    add(1'b1, 2'b10, 1'b0, 4'b0000, 4'b0010, 1'b1, 2'd1, 1'b0);
    add(1'b1, 2'b10, 1'b0, 4'b0000, 4'b0100, 1'b0, 2'd2, 1'b0);
    add(1'b1, 2'b10, 1'b0, 4'b0000, 4'b1000, 1'b0, 2'd3, 1'b0);
    add(1'b1, 2'b10, 1'b0, 4'b0000, 4'b0000, 1'b1, 2'd0, 1'b1);
    add(1'b1, 2'b10, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd1, 1'b0);
    add(1'b1, 2'b10, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd2, 1'b0);
    add(1'b1, 2'b10, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd3, 1'b0);
    add(1'b1, 2'b10, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b1);
    // Two shifts right, then en=0 with shift mode, then explicit hold
    add(1'b1, 2'b01, 1'b1, 4'b0000, 4'b1000, 1'b0, 2'd1, 1'b0);
    add(1'b1, 2'b01, 1'b1, 4'b0000, 4'b1100, 1'b0, 2'd2, 1'b0);
    add(1'b0, 2'b01, 1'b0, 4'b1111, 4'b1100, 1'b0, 2'd2, 1'b0);
    add(1'b0, 2'b01, 1'b0, 4'b1111, 4'b1100, 1'b0, 2'd2, 1'b0);
    add(1'b0, 2'b11, 1'b0, 4'b1111, 4'b1100, 1'b0, 2'd2, 1'b0);
    add(1'b1, 2'b00, 1'b1, 4'b1111, 4'b1100, 1'b0, 2'd2, 1'b0);
    add(1'b1, 2'b00, 1'b1, 4'b1111, 4'b1100, 1'b0, 2'd2, 1'b0);
    // Third shift (cnt=3) then load collides with the would-be 4th shift
    add(1'b1, 2'b01, 1'b1, 4'b0000, 4'b1110, 1'b0, 2'd3, 1'b0);
    add(1'b1, 2'b11, 1'b1, 4'b0110, 4'b0110, 1'b0, 2'd0, 1'b0);
    add(1'b1, 2'b01, 1'b0, 4'b0000, 4'b0011, 1'b0, 2'd1, 1'b0);
    add(1'b1, 2'b01, 1'b0, 4'b0000, 4'b0001, 1'b1, 2'd2, 1'b0);
    add(1'b1, 2'b01, 1'b0, 4'b0000, 4'b0000, 1'b1, 2'd3, 1'b0);
    add(1'b1, 2'b01, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b1);
    // Direction changes mid-frame: counter continues
    add(1'b1, 2'b10, 1'b1, 4'b0000, 4'b0001, 1'b0, 2'd1, 1'b0);
    add(1'b1, 2'b01, 1'b0, 4'b0000, 4'b0000, 1'b1, 2'd2, 1'b0);
    add(1'b1, 2'b10, 1'b1, 4'b0000, 4'b0001, 1'b0, 2'd3, 1'b0);
    add(1'b1, 2'b01, 1'b1, 4'b0000, 4'b1000, 1'b1, 2'd0, 1'b1);
    add(1'b1, 2'b00, 1'b0, 4'b0000, 4'b1000, 1'b1, 2'd0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].en, vecs[i].mode, vecs[i].din, vecs[i].d,
           vecs[i].o, vecs[i].dout, vecs[i].cnt, vecs[i].fd, i);
    end

    // Reset mid-frame: two shifts, 5 ns reset pulse, then a fresh 4-shift frame
    step(1'b1, 2'b01, 1'b1, 4'b0000, 4'b1100, 1'b0, 2'd1, 1'b0, 100);
    step(1'b1, 2'b01, 1'b1, 4'b0000, 4'b1110, 1'b0, 2'd2, 1'b0, 101);
    @(negedge clk);
    en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_o",   1, o,            4'b0000);
    check("mid_rst_cnt", 1, {2'b00, cnt}, 4'b0000);
    #4 rst_n = 1'b1;
    step(1'b1, 2'b01, 1'b1, 4'b0000, 4'b1000, 1'b0, 2'd1, 1'b0, 102);
    step(1'b1, 2'b01, 1'b1, 4'b0000, 4'b1100, 1'b0, 2'd2, 1'b0, 103);
    step(1'b1, 2'b01, 1'b1, 4'b0000, 4'b1110, 1'b0, 2'd3, 1'b0, 104);
    step(1'b1, 2'b01, 1'b1, 4'b0000, 4'b1111, 1'b0, 2'd0, 1'b1, 105);
    step(1'b0, 2'b01, 1'b1, 4'b0000, 4'b1111, 1'b0, 2'd0, 1'b0, 106);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
